// File: rtl/tcp_tx_pkg.sv
// Shared types and constants for the SiTCP transmit arbiter.
package tcp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_HDR2    = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_TRL_H   = 3'd5,
        ST_TRL_L   = 3'd6,
        ST_FLUSH   = 3'd7
    } tx_state_e;

    // Framing overhead wrapped around every granted packet.
    localparam int HDR_LEN = 3;
    localparam int TRL_LEN = 2;

    localparam logic [7:0]  HDR_SYNC_DEFAULT = 8'hA5;
    localparam logic [15:0] CNT_MAX          = 16'hFFFF;

    // Payload byte counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tcp_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after last_idx, cyclically.
module rr_arbiter #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [3:0]       last_idx,
    output logic [3:0]       grant_idx,
    output logic             grant_valid
);

    logic [N_SRC-1:0] hi_mask;
    logic [N_SRC-1:0] req_hi;

    // Requesters with an index above the last grant get first chance.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_mask
        assign hi_mask[gi] = (4'(gi) > last_idx);
    end
    assign req_hi = req & hi_mask;

    // Lowest set bit of the upper group wins; otherwise wrap to the lowest requester.
    always_comb begin
        grant_idx   = last_idx;
        grant_valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx   = 4'(i);
                grant_valid = 1'b1;
            end
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin packet framer feeding the SiTCP TX FIFO write port.
module tcp_tx_arbiter
    import tcp_tx_pkg::*;
#(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] HDR_SYNC = HDR_SYNC_DEFAULT
) (
    input  logic                 CLK_200M,
    input  logic                 SYS_RSTn,
    input  logic                 TCP_OPEN_ACK,
    input  logic                 FIFO_FULL,
    input  logic [N_SRC-1:0]     SRC_VALID,
    input  logic [N_SRC-1:0]     SRC_LAST,
    input  logic [8*N_SRC-1:0]   SRC_DATA,
    output logic [N_SRC-1:0]     SRC_RD,
    output logic [7:0]           TX_DATA,
    output logic                 TX_EN,
    output logic                 BUSY,
    output logic [3:0]           GRANT_ID,
    output logic                 PKT_DONE,
    output logic                 ABORT
);

    tx_state_e   state_reg, state_next;
    logic [3:0]  grant_reg, grant_next;
    logic [7:0]  seq_reg, seq_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_en_reg, tx_en_next;
    logic        pkt_done_reg, pkt_done_next;
    logic        abort_reg, abort_next;
    logic        rd_en;

    logic [N_SRC-1:0] gnt_oh;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic [3:0]       arb_idx;
    logic             arb_valid;

    rr_arbiter #(.N_SRC(N_SRC)) u_rr (
        .req         (SRC_VALID),
        .last_idx    (grant_reg),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // One-hot view of the granted source; ready only ever reaches that source.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign gnt_oh[gi] = (grant_reg == 4'(gi));
        assign SRC_RD[gi] = rd_en & gnt_oh[gi];
    end

    // Select the granted source's byte stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_oh[i]) begin
                sel_valid = SRC_VALID[i];
                sel_last  = SRC_LAST[i];
                sel_data  = SRC_DATA[8*i +: 8];
            end
        end
    end

    // Next-state, framing byte and ready generation.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        seq_next      = seq_reg;
        cnt_next      = cnt_reg;
        tx_data_next  = tx_data_reg;
        tx_en_next    = 1'b0;
        pkt_done_next = 1'b0;
        abort_next    = 1'b0;
        rd_en         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (TCP_OPEN_ACK && arb_valid) begin
                    grant_next = arb_idx;
                    cnt_next   = 16'd0;
                    state_next = ST_HDR0;
                end
            end
            ST_HDR0, ST_HDR1, ST_HDR2, ST_TRL_H, ST_TRL_L: begin
                if (!TCP_OPEN_ACK) begin
                    abort_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (!FIFO_FULL) begin
                    tx_en_next = 1'b1;
                    case (state_reg)
                        ST_HDR0: begin
                            tx_data_next = HDR_SYNC;
                            state_next   = ST_HDR1;
                        end
                        ST_HDR1: begin
                            tx_data_next = {4'h0, grant_reg};
                            state_next   = ST_HDR2;
                        end
                        ST_HDR2: begin
                            tx_data_next = seq_reg;
                            state_next   = ST_PAYLOAD;
                        end
                        ST_TRL_H: begin
                            tx_data_next = cnt_reg[15:8];
                            state_next   = ST_TRL_L;
                        end
                        default: begin
                            tx_data_next  = cnt_reg[7:0];
                            pkt_done_next = 1'b1;
                            seq_next      = seq_reg + 8'd1;
                            state_next    = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_PAYLOAD: begin
                rd_en = ~FIFO_FULL & TCP_OPEN_ACK;
                if (!TCP_OPEN_ACK) begin
                    abort_next = 1'b1;
                    state_next = ST_FLUSH;
                end else if (rd_en && sel_valid) begin
                    tx_en_next   = 1'b1;
                    tx_data_next = sel_data;
                    cnt_next     = sat_inc(cnt_reg);
                    if (sel_last) begin
                        state_next = ST_TRL_H;
                    end
                end
            end
            ST_FLUSH: begin
                // Discard the rest of the abandoned packet so the producer stays framed.
                rd_en = 1'b1;
                if (sel_valid && sel_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears a packet in flight at once.
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 4'(N_SRC - 1);
            seq_reg      <= 8'd0;
            cnt_reg      <= 16'd0;
            tx_data_reg  <= 8'd0;
            tx_en_reg    <= 1'b0;
            pkt_done_reg <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            seq_reg      <= seq_next;
            cnt_reg      <= cnt_next;
            tx_data_reg  <= tx_data_next;
            tx_en_reg    <= tx_en_next;
            pkt_done_reg <= pkt_done_next;
            abort_reg    <= abort_next;
        end
    end

    assign TX_DATA  = tx_data_reg;
    assign TX_EN    = tx_en_reg;
    assign BUSY     = (state_reg != ST_IDLE);
    assign GRANT_ID = grant_reg;
    assign PKT_DONE = pkt_done_reg;
    assign ABORT    = abort_reg;

endmodule

// File: doc/tcp_tx_arbiter.md
# tcp_tx_arbiter

Round-robin packet arbiter that shares the single SiTCP transmit byte stream among `N_SRC` data producers, such as TDC channel readouts. Each producer offers a byte stream terminated by a LAST flag. The arbiter wraps each granted packet in a 3-byte header and a 2-byte trailer and writes the result into the TCP TX FIFO write port (`TCP_TX_DATA_IN`/`TCP_TX_EN_IN`). It obeys the FIFO's programmable-full flag and the TCP connection state.

## Interface
- `N_SRC`, 4: number of requesters, 2..16.
- `HDR_SYNC`, 8'hA5: first header byte.
- `CLK_200M` in 1: system clock; all logic is in this single domain.
- `SYS_RSTn` in 1: asynchronous, active-low reset.
- `TCP_OPEN_ACK` in 1: TCP connection open; the FIFO is held in reset while this is low.
- `FIFO_FULL` in 1: TX FIFO programmable-full; no byte is written while it is high.
- `SRC_VALID` in `N_SRC`: per-source byte valid.
- `SRC_LAST` in `N_SRC`: per-source final byte of the packet, qualified by VALID.
- `SRC_DATA` in `8*N_SRC`: per-source byte; source i occupies [8i+7:8i].
- `SRC_RD` out `N_SRC`: per-source ready; a byte is consumed when VALID & RD.
- `TX_DATA` out 8: byte to the FIFO `din`.
- `TX_EN` out 1: FIFO `wr_en`, one byte per high cycle.
- `BUSY` out 1: a packet is in progress (state is not IDLE).
- `GRANT_ID` out 4: index of the current or last granted source.
- `PKT_DONE` out 1: one-cycle pulse when a packet's final trailer byte is written.
- `ABORT` out 1: one-cycle pulse when a packet is abandoned because `TCP_OPEN_ACK` dropped.

## Operation
- The FSM states are IDLE, HDR0, HDR1, HDR2, PAYLOAD, TRL_H, TRL_L and FLUSH.
- IDLE: when `TCP_OPEN_ACK`=1 and any `SRC_VALID` is set, grant the first valid source strictly after the last-granted index, searching cyclically.
  - Latch `GRANT_ID`, clear the 16-bit payload counter and go to HDR0.
- Each HDRx/TRLx state, when `FIFO_FULL`=0, registers one byte and advances. When `FIFO_FULL`=1 it holds with `TX_EN`=0. The bytes are:
  - HDR0 writes `HDR_SYNC`.
  - HDR1 writes {4'h0, GRANT_ID}.
  - HDR2 writes SEQ.
  - TRL_H writes CNT[15:8].
  - TRL_L writes CNT[7:0].
- PAYLOAD:
  - `SRC_RD[GRANT_ID]` = ~`FIFO_FULL` & `TCP_OPEN_ACK`; all other `SRC_RD` bits are 0.
  - On each handshake: `TX_DATA`<=byte, `TX_EN`<=1, CNT increments and saturates at 16'hFFFF.
  - A handshake with LAST goes to TRL_H.
- After TRL_L: pulse `PKT_DONE`, increment SEQ (8-bit, wraps 255→0) and return to IDLE.
- SEQ is global across sources and counts completed packets only.
- Reaching FLUSH:
  - `TCP_OPEN_ACK`=0 in any HDRx/TRLx state → pulse `ABORT`, go to IDLE.
  - `TCP_OPEN_ACK`=0 in PAYLOAD → pulse `ABORT`, go to FLUSH.
- FLUSH drains the granted source to keep producers aligned:
  - `SRC_RD[GRANT_ID]`=1 and `TX_EN`=0.
  - Bytes are discarded until a LAST handshake, then the FSM goes to IDLE.
  - SEQ is unchanged.
- A single-byte packet (VALID & LAST on the first PAYLOAD handshake) is legal: CNT=1.

## Timing
- Reset values:
  - `TX_EN`=0, `TX_DATA`=0, `SRC_RD`=0, `BUSY`=0, `PKT_DONE`=0, `ABORT`=0.
  - `GRANT_ID`=`N_SRC`-1, so source 0 wins the first arbitration.
  - SEQ=0, CNT=0, state IDLE.
- `TX_DATA`/`TX_EN` are registered. A byte handled in state S at cycle t appears at t+1.
- Request latency: `SRC_VALID` sampled in IDLE at cycle t; HDR0 is entered at t+1; first `TX_EN` at t+2.
- With no backpressure, an L-byte packet produces L+5 consecutive `TX_EN` cycles, followed by one IDLE cycle before the next grant.
- `FIFO_FULL` is used combinationally the same cycle. The FIFO's prog_full margin must be at least 2 bytes to absorb the registered write.
- `SRC_RD` is combinational from state, `FIFO_FULL` and `TCP_OPEN_ACK`. It never depends on `SRC_VALID`.
- A reset assertion mid-packet returns to the reset values immediately. No partial trailer is written.

## Structure
- Shared package `tcp_tx_pkg` holds:
  - the state enum;
  - the header/trailer byte-count constants (HDR_LEN=3, TRL_LEN=2);
  - the default `HDR_SYNC`.
- One sub-module, `rr_arbiter`: `N_SRC`-wide round-robin priority pick. Inputs are the request vector and the last index; outputs are the grant index and a valid flag. It is purely combinational.
- The FSM, counters and output registers live in the top module.

## Test plan
- **Single source:** reset, `TCP_OPEN_ACK`=1, source 2 sends 4 bytes 11,22,33,44 with LAST on 44. Required stream: A5,02,00,11,22,33,44,00,04; `PKT_DONE` pulses once; SEQ becomes 1.
- **Contention:** all four sources valid with 1-byte packets. Grants occur in order 0,1,2,3,0; header SEQ bytes are 00..04.
- **Backpressure:** `FIFO_FULL` held high for 5 cycles mid-payload. `TX_EN`=0 and `SRC_RD`=0 throughout; no byte is lost or duplicated; trailer count is correct.
- **Disconnect mid-payload:** `TCP_OPEN_ACK` drops after 2 of 6 payload bytes.
  - `ABORT` pulses; the remaining 4 bytes are drained with `TX_EN`=0.
  - IDLE follows; SEQ is unchanged.
  - The next packet header carries the old SEQ.
- **Sequence wrap and saturation:**
  - 256 packets: SEQ goes 255→0.
  - One 70000-byte packet: trailer reads FF,FF.
- **Async reset:** `SYS_RSTn` pulsed low during HDR1. All outputs are at their reset values within the same cycle; the next grant goes to source 0.
